// File: rtl/dense_layer_seq.sv
// Time-multiplexed fully-connected layer: runtime-loadable weights/biases, one serial MAC per neuron.
// First result N_IN+2 cycles after the last feature, then N_IN+1 per neuron; out_ready low freezes EMIT.
module dense_layer_seq #(
  parameter int WIDTH = 25,
  parameter int NFRAC = 12,
  parameter int N_IN  = 32,
  parameter int N_OUT = 5,
  parameter int RELU  = 0,
  localparam int AW   = $clog2(N_IN*N_OUT + N_OUT)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic signed [WIDTH-1:0] wr_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    out_last,
  output logic                    busy
);

  localparam int NW   = N_IN*N_OUT + N_OUT;
  localparam int IW   = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int JW   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int ACCW = 2*WIDTH + $clog2(N_IN) + 1;

  localparam logic [AW:0]   NW_L      = (AW+1)'(NW);
  localparam logic [AW-1:0] BIAS_BASE = AW'(N_IN*N_OUT);
  localparam logic [AW-1:0] STRIDE    = AW'(N_OUT);
  localparam logic [IW-1:0] LAST_I    = IW'(N_IN-1);
  localparam logic [JW-1:0] LAST_J    = JW'(N_OUT-1);
  localparam logic signed [ACCW-1:0] SAT_MAX = (ACCW'(1) <<< (WIDTH-1)) - ACCW'(1);
  localparam logic signed [ACCW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, LOAD, MAC, EMIT} state_t;

  state_t                  state;
  logic signed [WIDTH-1:0] mem  [NW];
  logic signed [WIDTH-1:0] xbuf [N_IN];
  logic [IW-1:0]           idx;
  logic [JW-1:0]           j;
  logic [AW-1:0]           wptr;
  logic                    mac_first;
  logic signed [ACCW-1:0]  acc;

  logic                      accept;
  logic signed [WIDTH-1:0]   x_cur;
  logic signed [WIDTH-1:0]   w_cur;
  logic signed [WIDTH-1:0]   b_cur;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACCW-1:0]    bias_ext;
  logic signed [ACCW-1:0]    acc_next;
  logic signed [ACCW-1:0]    shifted;
  logic signed [WIDTH-1:0]   res;

  assign accept   = in_valid & in_ready;
  assign x_cur    = xbuf[idx];
  assign w_cur    = mem[wptr];
  assign b_cur    = mem[BIAS_BASE + AW'(j)];
  assign prod     = (2*WIDTH)'(x_cur) * (2*WIDTH)'(w_cur);
  assign bias_ext = {{(ACCW-WIDTH){b_cur[WIDTH-1]}}, b_cur};
  assign acc_next = acc + {{(ACCW-2*WIDTH){prod[2*WIDTH-1]}}, prod};
  assign shifted  = acc_next >>> NFRAC;

  // Result of the final product: truncate, saturate, then optional ReLU.
  always_comb begin
    res = shifted[WIDTH-1:0];
    if (shifted > SAT_MAX)
      res = SAT_MAX[WIDTH-1:0];
    else if (shifted < SAT_MIN)
      res = SAT_MIN[WIDTH-1:0];
    if (RELU != 0 && res[WIDTH-1])
      res = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NW; k++) mem[k] <= '0;
    end else if (wr_en && !busy && ({1'b0, wr_addr} < NW_L)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N_IN; k++) xbuf[k] <= '0;
    end else if (accept) begin
      xbuf[idx] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      idx       <= '0;
      j         <= '0;
      wptr      <= '0;
      mac_first <= 1'b0;
      acc       <= '0;
    end else begin
      case (state)
        IDLE, LOAD: begin
          if (accept) begin
            state <= LOAD;
            busy  <= 1'b1;
            if (idx == LAST_I) begin
              in_ready <= 1'b0;
              idx      <= '0;
            end else begin
              idx <= idx + IW'(1);
            end
          end else if (state == LOAD && !in_ready) begin
            // One dead cycle after the last feature before neuron 0 starts.
            state     <= MAC;
            j         <= '0;
            wptr      <= '0;
            mac_first <= 1'b1;
          end
        end
        MAC: begin
          if (mac_first) begin
            acc       <= bias_ext <<< NFRAC;
            mac_first <= 1'b0;
          end else begin
            acc  <= acc_next;
            wptr <= wptr + STRIDE;
            if (idx == LAST_I) begin
              idx       <= '0;
              state     <= EMIT;
              out_valid <= 1'b1;
              out_data  <= res;
              out_last  <= (j == LAST_J);
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (j == LAST_J) begin
              state    <= IDLE;
              busy     <= 1'b0;
              in_ready <= 1'b1;
            end else begin
              j         <= j + JW'(1);
              wptr      <= AW'(j) + AW'(1);
              mac_first <= 1'b1;
              state     <= MAC;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_layer_seq.sv
// Bench for dense_layer_seq: directed table, hand-written corner sequences and randomized vectors
// checked against an arithmetic reference model; a RELU=0 and a RELU=1 instance share all stimulus.
module tb_dense_layer_seq;

  localparam int WIDTH = 25;
  localparam int NFRAC = 12;
  localparam int N_IN  = 32;
  localparam int N_OUT = 5;
  localparam int NW    = N_IN*N_OUT + N_OUT;
  localparam int AW    = $clog2(NW);
  localparam longint SMAX = (longint'(1) <<< (WIDTH-1)) - 1;
  localparam longint SMIN = -(longint'(1) <<< (WIDTH-1));

  logic clk = 1'b0;
  logic reset, wr_en, in_valid, out_ready;
  logic [AW-1:0] wr_addr;
  logic signed [WIDTH-1:0] wr_data, in_data;
  logic in_ready0, out_valid0, out_last0, busy0;
  logic in_ready1, out_valid1, out_last1, busy1;
  logic signed [WIDTH-1:0] out_data0, out_data1;

  dense_layer_seq #(.WIDTH(WIDTH), .NFRAC(NFRAC), .N_IN(N_IN), .N_OUT(N_OUT), .RELU(0)) u_lin (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_last(out_last0), .busy(busy0));

  dense_layer_seq #(.WIDTH(WIDTH), .NFRAC(NFRAC), .N_IN(N_IN), .N_OUT(N_OUT), .RELU(1)) u_relu (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_last(out_last1), .busy(busy1));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  longint wm [N_IN][N_OUT];
  longint bm [N_OUT];
  longint xv [N_IN];
  longint exp0 [N_OUT];
  longint exp1 [N_OUT];

  typedef struct {
    string  name;
    longint wval;
    bit     col0;
    longint xval;
    longint bstep;
    longint exp [N_OUT];
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: bias scaled to product precision, exact sum, floor shift, clamp, optional ReLU.
  function automatic longint model(input int jj, input bit relu);
    longint acc;
    longint r;
    acc = bm[jj] * (longint'(1) <<< NFRAC);
    for (int i = 0; i < N_IN; i++) acc += xv[i] * wm[i][jj];
    r = acc >>> NFRAC;
    if (r > SMAX) r = SMAX;
    if (r < SMIN) r = SMIN;
    if (relu && r < 0) r = 0;
    return r;
  endfunction

  function automatic longint rnd_word();
    logic signed [WIDTH-1:0] v;
    if ($urandom_range(0, 3) == 0) v = WIDTH'($urandom);
    else v = WIDTH'($urandom_range(0, 16383)) - WIDTH'(8192);
    return longint'(v);
  endfunction

  task automatic wr(input int addr, input longint val);
    logic signed [WIDTH-1:0] t;
    t = WIDTH'(val);
    wr_en = 1'b1; wr_addr = AW'(addr); wr_data = t;
    tick();
    wr_en = 1'b0;
    if (addr < N_IN*N_OUT) wm[addr / N_OUT][addr % N_OUT] = longint'(t);
    else if (addr < NW) bm[addr - N_IN*N_OUT] = longint'(t);
  endtask

  task automatic push_all();
    for (int i = 0; i < N_IN; i++)
      for (int jj = 0; jj < N_OUT; jj++) wr(i*N_OUT + jj, wm[i][jj]);
    for (int jj = 0; jj < N_OUT; jj++) wr(N_IN*N_OUT + jj, bm[jj]);
  endtask

  task automatic clear_model();
    for (int i = 0; i < N_IN; i++)
      for (int jj = 0; jj < N_OUT; jj++) wm[i][jj] = 0;
    for (int jj = 0; jj < N_OUT; jj++) bm[jj] = 0;
  endtask

  task automatic model_exp();
    for (int jj = 0; jj < N_OUT; jj++) begin
      exp0[jj] = model(jj, 1'b0);
      exp1[jj] = model(jj, 1'b1);
    end
  endtask

  task automatic send_vector(input bit gaps);
    int k;
    int guard;
    bit rdy;
    k = 0;
    guard = 0;
    while (k < N_IN && guard < 1000) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0; in_data = WIDTH'($urandom);
      end else begin
        in_valid = 1'b1; in_data = WIDTH'(xv[k]);
      end
      rdy = in_ready0;
      tick();
      if (in_valid && rdy) k++;
      guard++;
    end
    in_valid = 1'b0;
    if (k < N_IN) check("send_timeout", k, N_IN);
  endtask

  task automatic collect(input int nneur, input int stall_max, input bit lock_test);
    int cyc;
    int ns;
    longint held, d0, d1;
    bit l0, l1, v1;
    for (int n = 0; n < nneur; n++) begin
      cyc = 0;
      while (!out_valid0 && cyc < 200) begin
        in_valid = 1'($urandom_range(0, 1)); in_data = WIDTH'($urandom);
        tick();
        cyc++;
      end
      in_valid = 1'b0;
      check($sformatf("latency_n%0d", n), cyc, (n == 0) ? N_IN + 2 : N_IN + 1);
      if (!out_valid0) return;
      held = longint'(out_data0);
      if (lock_test && n == 0) begin
        for (int s = 0; s < 10; s++) begin
          out_ready = 1'b0;
          wr_en = 1'b1; wr_addr = AW'(N_IN*N_OUT); wr_data = WIDTH'(777);
          tick();
          check("stall_data", longint'(out_data0), held);
          check("stall_in_ready", longint'(in_ready0), 0);
          check("stall_valid", longint'(out_valid0), 1);
        end
        wr_en = 1'b0;
      end else begin
        ns = $urandom_range(0, stall_max);
        for (int s = 0; s < ns; s++) begin
          out_ready = 1'b0;
          tick();
          check("bp_data", longint'(out_data0), held);
        end
      end
      out_ready = 1'b1;
      d0 = longint'(out_data0); d1 = longint'(out_data1);
      l0 = out_last0; l1 = out_last1; v1 = out_valid1;
      tick();
      out_ready = 1'b0;
      check($sformatf("data_n%0d", n), d0, exp0[n]);
      check($sformatf("relu_data_n%0d", n), d1, exp1[n]);
      check($sformatf("last_n%0d", n), longint'(l0), (n == N_OUT-1) ? 1 : 0);
      check($sformatf("relu_last_n%0d", n), longint'(l1), (n == N_OUT-1) ? 1 : 0);
      check("relu_valid", longint'(v1), 1);
    end
    if (nneur == N_OUT) begin
      check("done_busy", longint'(busy0), 0);
      check("done_in_ready", longint'(in_ready0), 1);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{"bias_only", 0, 1'b0, 1234, 2048, '{0, 2048, 4096, 6144, 8192}};
    tbl[1] = '{"unity_sum", 4096, 1'b1, 4096, 0, '{131072, 0, 0, 0, 0}};
    tbl[2] = '{"sat_pos", 16777215, 1'b0, 16777215, 0,
               '{16777215, 16777215, 16777215, 16777215, 16777215}};
    tbl[3] = '{"sat_neg", -16777216, 1'b0, 16777215, 0,
               '{-16777216, -16777216, -16777216, -16777216, -16777216}};
    tbl[4] = '{"half_weights", 2048, 1'b0, 3, 4096, '{48, 4144, 8240, 12336, 16432}};
    tbl[5] = '{"floor_shift", -1, 1'b0, 1, 0, '{-1, -1, -1, -1, -1}};

    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    clear_model();
    tick(); tick();
    reset = 1'b0;
    check("rst_in_ready", longint'(in_ready0), 1);
    check("rst_out_valid", longint'(out_valid0), 0);
    check("rst_out_data", longint'(out_data0), 0);
    check("rst_out_last", longint'(out_last0), 0);
    check("rst_busy", longint'(busy0), 0);
    check("rst_relu_in_ready", longint'(in_ready1), 1);

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < N_IN; i++) begin
        xv[i] = tbl[t].xval;
        for (int jj = 0; jj < N_OUT; jj++)
          wm[i][jj] = (tbl[t].col0 && jj != 0) ? 0 : tbl[t].wval;
      end
      for (int jj = 0; jj < N_OUT; jj++) begin
        bm[jj] = tbl[t].bstep * jj;
        exp0[jj] = tbl[t].exp[jj];
        exp1[jj] = (tbl[t].exp[jj] < 0) ? 0 : tbl[t].exp[jj];
      end
      push_all();
      send_vector(t[0]);
      collect(N_OUT, 0, 1'b0);
    end

    // ReLU: a single negative contribution to neuron 1
    clear_model();
    wm[0][1] = -4096;
    for (int i = 0; i < N_IN; i++) xv[i] = 0;
    xv[0] = 4096;
    push_all();
    exp0 = '{0, -4096, 0, 0, 0};
    exp1 = '{0, 0, 0, 0, 0};
    send_vector(1'b0);
    collect(N_OUT, 0, 1'b0);

    // Randomized vectors with reloads, out-of-range writes, input gaps and backpressure
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < N_IN; i++) begin
        xv[i] = rnd_word();
        for (int jj = 0; jj < N_OUT; jj++) wm[i][jj] = rnd_word();
      end
      for (int jj = 0; jj < N_OUT; jj++) bm[jj] = rnd_word();
      push_all();
      wr($urandom_range(NW, (1 << AW) - 1), rnd_word());
      model_exp();
      send_vector(1'b1);
      collect(N_OUT, 3, 1'b0);
    end

    // Backpressure with a bias write attempted while busy, then a vector on the same weights
    for (int i = 0; i < N_IN; i++) xv[i] = rnd_word();
    bm[0] = 1000;
    wr(N_IN*N_OUT, bm[0]);
    model_exp();
    send_vector(1'b0);
    collect(N_OUT, 0, 1'b1);
    for (int i = 0; i < N_IN; i++) xv[i] = rnd_word();
    model_exp();
    send_vector(1'b1);
    collect(N_OUT, 2, 1'b0);

    // Reset during neuron 2 MAC aborts the vector and clears storage
    for (int i = 0; i < N_IN; i++) xv[i] = rnd_word();
    model_exp();
    send_vector(1'b0);
    collect(2, 0, 1'b0);
    for (int s = 0; s < 10; s++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_out_valid", longint'(out_valid0), 0);
    check("midrst_busy", longint'(busy0), 0);
    check("midrst_in_ready", longint'(in_ready0), 1);
    check("midrst_out_data", longint'(out_data0), 0);
    clear_model();
    for (int i = 0; i < N_IN; i++) xv[i] = rnd_word();
    model_exp();
    send_vector(1'b1);
    collect(N_OUT, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
